pipe_hazard_ctrl: RTL and testbench



---
 rtl/pipe_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipe_hazard_ctrl_load_branch_hazard.sv | 24 ++
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the 4-stage pipeline hazard controller:
// RV32 opcodes, register names, instruction field helpers and FSM states.
package pipe_hazard_ctrl_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_MEM_WAIT = 2'd2
  } pipe_state_e;

  function automatic logic [6:0] opcode_of(input logic [31:0] inst);
    return inst[6:0];
  endfunction

  function automatic logic [4:0] rd_of(input logic [31:0] inst);
    return inst[11:7];
  endfunction

  function automatic logic [4:0] rs1_of(input logic [31:0] inst);
    return inst[19:15];
  endfunction

  function automatic logic [4:0] rs2_of(input logic [31:0] inst);
    return inst[24:20];
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_load_branch_hazard.sv
// Combinational detect of a load in M feeding a branch comparator in X.
// Kept standalone so the forwarding selectors can reuse the same decode.
module load_branch_hazard
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [31:0] inst_x_i,
  input  logic [31:0] inst_m_i,
  output logic        lb_haz_o
);

  logic       m_is_load;
  logic       x_is_branch;
  logic [4:0] m_rd;
  logic       rd_match;

  assign m_is_load   = (opcode_of(inst_m_i) == OPC_LOAD);
  assign x_is_branch = (opcode_of(inst_x_i) == OPC_BRANCH);
  assign m_rd        = rd_of(inst_m_i);
  assign rd_match    = (m_rd == rs1_of(inst_x_i)) || (m_rd == rs2_of(inst_x_i));

  // Loads to x0 never write anything, so they cannot create a dependency.
  assign lb_haz_o = m_is_load && (m_rd != REG_X0) && x_is_branch && rd_match;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the IF/X/M/W pipeline: load-to-branch stall,
// two-cycle mispredict flush, data-memory freeze, perf counters, timeout flag.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_X,
  input  logic [31:0]      inst_M,
  input  logic             br_mispredict_X,
  input  logic             dmem_req_M,
  input  logic             dmem_ready,
  output logic             stall_F,
  output logic             stall_X,
  output logic             bubble_M,
  output logic             freeze_all,
  output logic             flush_F,
  output logic             redirect,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  pipe_state_e       state_q, state_d;
  pipe_state_e       ret_q, ret_d;
  pipe_state_e       eff_state;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;
  logic              lb_haz;
  logic              frozen;

  load_branch_hazard u_lb_haz (
    .inst_x_i (inst_X),
    .inst_m_i (inst_M),
    .lb_haz_o (lb_haz)
  );

  assign frozen = dmem_req_M & ~dmem_ready;

  // Leaving MEM_WAIT, the release cycle behaves as the state we were frozen in.
  assign eff_state = (state_q == ST_MEM_WAIT) ? ret_q : state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      ret_q      <= ST_RUN;
      wait_cnt_q <= '0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      wait_cnt_q <= wait_cnt_d;
      mem_err_q  <= mem_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    wait_cnt_d = '0;
    mem_err_d  = mem_err_q;
    if (frozen) begin
      state_d = ST_MEM_WAIT;
      if (state_q != ST_MEM_WAIT) begin
        ret_d = state_q;
      end
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
      if (wait_cnt_q >= WAIT_LAST) begin
        mem_err_d = 1'b1;
      end
    end else begin
      unique case (eff_state)
        ST_RUN:   state_d = (!lb_haz && br_mispredict_X) ? ST_FLUSH : ST_RUN;
        ST_FLUSH: state_d = ST_RUN;
        default:  state_d = ST_RUN;
      endcase
    end
  end

  // In FLUSH, X holds a squashed NOP so hazard and mispredict inputs are ignored.
  always_comb begin
    stall_F    = 1'b0;
    stall_X    = 1'b0;
    bubble_M   = 1'b0;
    freeze_all = 1'b0;
    flush_F    = 1'b0;
    redirect   = 1'b0;
    if (rst_n) begin
      if (frozen) begin
        freeze_all = 1'b1;
      end else begin
        unique case (eff_state)
          ST_RUN: begin
            if (lb_haz) begin
              stall_F  = 1'b1;
              stall_X  = 1'b1;
              bubble_M = 1'b1;
            end else if (br_mispredict_X) begin
              redirect = 1'b1;
              flush_F  = 1'b1;
            end
          end
          ST_FLUSH: flush_F = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((stall_F || freeze_all) && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush_F && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; a second instance with
// 2-bit counters exercises counter saturation.
module tb_pipe_hazard_ctrl;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_X;
  logic [31:0] inst_M;
  logic        br_mispredict_X;
  logic        dmem_req_M;
  logic        dmem_ready;

  logic        stall_F, stall_X, bubble_M, freeze_all, flush_F, redirect, mem_err;
  logic [31:0] stall_cnt, flush_cnt;

  logic        s_stall_F, s_stall_X, s_bubble_M, s_freeze_all, s_flush_F, s_redirect, s_mem_err;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  logic [5:0]  ctrl;
  logic [5:0]  s_ctrl;

  int checks = 0;
  int errors = 0;

  assign ctrl   = {stall_F, stall_X, bubble_M, freeze_all, flush_F, redirect};
  assign s_ctrl = {s_stall_F, s_stall_X, s_bubble_M, s_freeze_all, s_flush_F, s_redirect};

  pipe_hazard_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .inst_X          (inst_X),
    .inst_M          (inst_M),
    .br_mispredict_X (br_mispredict_X),
    .dmem_req_M      (dmem_req_M),
    .dmem_ready      (dmem_ready),
    .stall_F         (stall_F),
    .stall_X         (stall_X),
    .bubble_M        (bubble_M),
    .freeze_all      (freeze_all),
    .flush_F         (flush_F),
    .redirect        (redirect),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt),
    .mem_err         (mem_err)
  );

  pipe_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(8)) dut_sat (
    .clk             (clk),
    .rst_n           (rst_n),
    .inst_X          (inst_X),
    .inst_M          (inst_M),
    .br_mispredict_X (br_mispredict_X),
    .dmem_req_M      (dmem_req_M),
    .dmem_ready      (dmem_ready),
    .stall_F         (s_stall_F),
    .stall_X         (s_stall_X),
    .bubble_M        (s_bubble_M),
    .freeze_all      (s_freeze_all),
    .flush_F         (s_flush_F),
    .redirect        (s_redirect),
    .stall_cnt       (s_stall_cnt),
    .flush_cnt       (s_flush_cnt),
    .mem_err         (s_mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk_load(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b010, rd, 7'b0000011};
  endfunction

  function automatic logic [31:0] mk_branch(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
  endfunction

  function automatic logic [31:0] mk_jalr(input logic [4:0] rd, input logic [4:0] rs1);
    return {12'd0, rs1, 3'b000, rd, 7'b1100111};
  endfunction

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic [31:0] ix, input logic [31:0] im,
                       input logic mp, input logic req, input logic rdy);
    @(negedge clk);
    inst_X          = ix;
    inst_M          = im;
    br_mispredict_X = mp;
    dmem_req_M      = req;
    dmem_ready      = rdy;
    #1;
  endtask

  task automatic do_reset();
    rst_n           = 1'b0;
    inst_X          = NOP;
    inst_M          = NOP;
    br_mispredict_X = 1'b0;
    dmem_req_M      = 1'b0;
    dmem_ready      = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n           = 1'b0;
    inst_X          = mk_branch(5'd5, 5'd6);
    inst_M          = mk_load(5'd5, 5'd1);
    br_mispredict_X = 1'b1;
    dmem_req_M      = 1'b1;
    dmem_ready      = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (ctrl !== 6'b000000) begin
      errors++; $display("[TB] FAIL reset_ctrl got=%b exp=%b", ctrl, 6'b000000);
    end
    checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || mem_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_regs got=%0d/%0d/%b exp=0/0/0", stall_cnt, flush_cnt, mem_err);
    end
    do_reset();
  endtask

  task automatic test_load_branch();
    do_reset();
    drive(mk_branch(5'd5, 5'd6), mk_load(5'd5, 5'd1), 1'b1, 1'b1, 1'b1);
    checks++;
    if (ctrl !== 6'b111000) begin
      errors++; $display("[TB] FAIL lb_rs1_stall got=%b exp=%b", ctrl, 6'b111000);
    end
    drive(mk_branch(5'd5, 5'd6), NOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 6'b000000) begin
      errors++; $display("[TB] FAIL lb_release got=%b exp=%b", ctrl, 6'b000000);
    end
    checks++;
    if (stall_cnt !== 32'd1) begin
      errors++; $display("[TB] FAIL lb_stall_cnt got=%0d exp=1", stall_cnt);
    end
    drive(mk_branch(5'd7, 5'd9), mk_load(5'd9, 5'd2), 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 6'b111000) begin
      errors++; $display("[TB] FAIL lb_rs2_stall got=%b exp=%b", ctrl, 6'b111000);
    end
    drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (stall_cnt !== 32'd2 || flush_cnt !== 32'd0) begin
      errors++; $display("[TB] FAIL lb_cnts got=%0d/%0d exp=2/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_no_stall();
    do_reset();
    drive(mk_branch(5'd0, 5'd6), mk_load(5'd0, 5'd1), 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 6'b000000) begin
      errors++; $display("[TB] FAIL nostall_x0 got=%b exp=%b", ctrl, 6'b000000);
    end
    drive(mk_jalr(5'd1, 5'd5), mk_load(5'd5, 5'd1), 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 6'b000000) begin
      errors++; $display("[TB] FAIL nostall_jalr got=%b exp=%b", ctrl, 6'b000000);
    end
    drive(mk_branch(5'd7, 5'd8), mk_load(5'd5, 5'd1), 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 6'b000000) begin
      errors++; $display("[TB] FAIL nostall_nomatch got=%b exp=%b", ctrl, 6'b000000);
    end
    drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++; $display("[TB] FAIL nostall_cnt got=%0d exp=0", stall_cnt);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    drive(NOP, NOP, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 6'b000011) begin
      errors++; $display("[TB] FAIL mp_T got=%b exp=%b", ctrl, 6'b000011);
    end
    // Mispredict and load-branch inputs must both be masked during FLUSH.
    drive(mk_branch(5'd5, 5'd6), mk_load(5'd5, 5'd1), 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 6'b000010) begin
      errors++; $display("[TB] FAIL mp_T1 got=%b exp=%b", ctrl, 6'b000010);
    end
    drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 6'b000000) begin
      errors++; $display("[TB] FAIL mp_T2 got=%b exp=%b", ctrl, 6'b000000);
    end
    checks++;
    if (flush_cnt !== 32'd2 || stall_cnt !== 32'd0) begin
      errors++; $display("[TB] FAIL mp_cnts got=%0d/%0d exp=2/0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_mispredict_freeze();
    do_reset();
    drive(NOP, NOP, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 6'b000011) begin
      errors++; $display("[TB] FAIL mpf_T got=%b exp=%b", ctrl, 6'b000011);
    end
    for (int k = 1; k <= 3; k++) begin
      drive(NOP, NOP, 1'b0, 1'b1, 1'b0);
      checks++;
      if (ctrl !== 6'b000100) begin
        errors++; $display("[TB] FAIL mpf_freeze%0d got=%b exp=%b", k, ctrl, 6'b000100);
      end
    end
    drive(NOP, NOP, 1'b0, 1'b1, 1'b1);
    checks++;
    if (ctrl !== 6'b000010) begin
      errors++; $display("[TB] FAIL mpf_flush2 got=%b exp=%b", ctrl, 6'b000010);
    end
    drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 6'b000000) begin
      errors++; $display("[TB] FAIL mpf_run got=%b exp=%b", ctrl, 6'b000000);
    end
    checks++;
    if (stall_cnt !== 32'd3 || flush_cnt !== 32'd2) begin
      errors++; $display("[TB] FAIL mpf_cnts got=%0d/%0d exp=3/2", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      drive(NOP, NOP, 1'b0, 1'b1, 1'b0);
      checks++;
      if (ctrl !== 6'b000100 || mem_err !== (k >= 5)) begin
        errors++; $display("[TB] FAIL to_wait%0d got=%b/%b exp=%b/%b", k, ctrl, mem_err, 6'b000100, (k >= 5));
      end
    end
    drive(NOP, NOP, 1'b0, 1'b1, 1'b1);
    checks++;
    if (ctrl !== 6'b000000 || mem_err !== 1'b1) begin
      errors++; $display("[TB] FAIL to_release got=%b/%b exp=%b/1", ctrl, mem_err, 6'b000000);
    end
    drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (mem_err !== 1'b1) begin
      errors++; $display("[TB] FAIL to_sticky got=%b exp=1", mem_err);
    end
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    drive(NOP, NOP, 1'b1, 1'b0, 1'b0);
    drive(NOP, NOP, 1'b0, 1'b1, 1'b0);
    drive(NOP, NOP, 1'b0, 1'b1, 1'b0);
    checks++;
    if (ctrl !== 6'b000100 || stall_cnt !== 32'd1 || flush_cnt !== 32'd1) begin
      errors++; $display("[TB] FAIL rmw_pre got=%b/%0d/%0d exp=%b/1/1", ctrl, stall_cnt, flush_cnt, 6'b000100);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctrl !== 6'b000000 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0 || mem_err !== 1'b0) begin
      errors++; $display("[TB] FAIL rmw_async got=%b/%0d/%0d/%b exp=%b/0/0/0", ctrl, stall_cnt, flush_cnt, mem_err, 6'b000000);
    end
    @(negedge clk);
    dmem_req_M = 1'b0;
    rst_n      = 1'b1;
    // A pending FLUSH return would show flush_F without redirect here.
    drive(NOP, NOP, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 6'b000011) begin
      errors++; $display("[TB] FAIL rmw_run got=%b exp=%b", ctrl, 6'b000011);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(mk_branch(5'd8, 5'd7), mk_load(5'd7, 5'd2), 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 6'b111000) begin
      errors++; $display("[TB] FAIL b2b_stall got=%b exp=%b", ctrl, 6'b111000);
    end
    drive(mk_branch(5'd8, 5'd7), NOP, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 6'b000011) begin
      errors++; $display("[TB] FAIL b2b_redirect got=%b exp=%b", ctrl, 6'b000011);
    end
    drive(NOP, NOP, 1'b1, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 6'b000010) begin
      errors++; $display("[TB] FAIL b2b_flush got=%b exp=%b", ctrl, 6'b000010);
    end
    drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (ctrl !== 6'b000000 || stall_cnt !== 32'd1 || flush_cnt !== 32'd2) begin
      errors++; $display("[TB] FAIL b2b_end got=%b/%0d/%0d exp=%b/1/2", ctrl, stall_cnt, flush_cnt, 6'b000000);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      drive(NOP, NOP, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (s_ctrl !== 6'b000100) begin
      errors++; $display("[TB] FAIL sat_ctrl got=%b exp=%b", s_ctrl, 6'b000100);
    end
    drive(NOP, NOP, 1'b0, 1'b0, 1'b0);
    checks++;
    if (s_stall_cnt !== 2'd3 || s_flush_cnt !== 2'd0 || s_mem_err !== 1'b0) begin
      errors++; $display("[TB] FAIL sat_cnt got=%0d/%0d/%b exp=3/0/0", s_stall_cnt, s_flush_cnt, s_mem_err);
    end
    checks++;
    if (stall_cnt !== 32'd5) begin
      errors++; $display("[TB] FAIL sat_wide_cnt got=%0d exp=5", stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_load_branch();
    test_no_stall();
    test_mispredict();
    test_mispredict_freeze();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
